// File: rtl/eth_intr_pkg.sv
// Shared constants and types for the Ethernet MAC interrupt controller.
// The ETH_INTR_COALESCE_EN build uses intr_state_e for the holdoff FSM.
package eth_intr_pkg;

  localparam int NUM_SRC_DEF = 7;
  localparam int HOLD_W_DEF  = 16;

  localparam logic [1:0] ADDR_INT_SOURCE = 2'd0;
  localparam logic [1:0] ADDR_INT_MASK   = 2'd1;
  localparam logic [1:0] ADDR_INT_RAW    = 2'd2;
  localparam logic [1:0] ADDR_HOLDOFF    = 2'd3;

  typedef enum logic [2:0] {
    SRC_TXB  = 3'd0,
    SRC_TXE  = 3'd1,
    SRC_RXB  = 3'd2,
    SRC_RXE  = 3'd3,
    SRC_BUSY = 3'd4,
    SRC_TXC  = 3'd5,
    SRC_RXC  = 3'd6
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_ASSERT = 2'd2
  } intr_state_e;

endpackage

// File: rtl/eth_intr_holdoff.sv
// Interrupt coalescing FSM: delays intr by HOLDOFF cycles of continuous pending.
// Instantiated by eth_intr_ctrl only when ETH_INTR_COALESCE_EN is defined.
module eth_intr_holdoff #(
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pending_next_i,
  input  logic [HOLD_W-1:0] holdoff_i,
  output logic              intr_o
);
  import eth_intr_pkg::*;

  localparam logic [HOLD_W-1:0] CNT_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] CNT_MAX = {HOLD_W{1'b1}};

  intr_state_e       state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              intr_q;

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!pending_next_i) begin
          state_d = ST_IDLE;
        end else if (holdoff_i == {HOLD_W{1'b0}}) begin
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!pending_next_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == holdoff_i) begin
          state_d = ST_ASSERT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ASSERT: begin
        if (!pending_next_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered intr
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {HOLD_W{1'b0}};
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= (state_d == ST_ASSERT);
    end
  end

  assign intr_o = intr_q;

endmodule

// File: rtl/eth_intr_ctrl.sv
// Ethernet MAC interrupt aggregation: sticky W1C status, mask, registered intr.
// Define ETH_INTR_COALESCE_EN to add the HOLDOFF register and coalescing FSM.
module eth_intr_ctrl #(
  parameter int NUM_SRC = eth_intr_pkg::NUM_SRC_DEF,
  parameter int HOLD_W  = eth_intr_pkg::HOLD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               intr
);
  import eth_intr_pkg::*;

  logic [NUM_SRC-1:0] status_q, status_d, mask_q, mask_d, clr_s;
  logic [31:0]        rdata_q, rdata_d;
  logic [HOLD_W-1:0]  holdoff_rd_s;
  logic               pending_next_s;
  logic               unused_wdata_s;

  assign unused_wdata_s = ^reg_wdata;

  // Status/mask next state; a same-cycle event beats a W1C clear
  always_comb begin
    if (reg_wr && (reg_addr == ADDR_INT_SOURCE)) begin
      clr_s = reg_wdata[NUM_SRC-1:0];
    end else begin
      clr_s = {NUM_SRC{1'b0}};
    end
    status_d = (status_q & ~clr_s) | evt_i;
    if (reg_wr && (reg_addr == ADDR_INT_MASK)) begin
      mask_d = reg_wdata[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    pending_next_s = |(status_d & mask_d);
  end

  // Read mux from pre-write register values
  always_comb begin
    rdata_d = rdata_q;
    if (reg_rd) begin
      rdata_d = 32'd0;
      case (reg_addr)
        ADDR_INT_SOURCE: rdata_d[NUM_SRC-1:0] = status_q & mask_q;
        ADDR_INT_MASK:   rdata_d[NUM_SRC-1:0] = mask_q;
        ADDR_INT_RAW:    rdata_d[NUM_SRC-1:0] = status_q;
        ADDR_HOLDOFF:    rdata_d[HOLD_W-1:0]  = holdoff_rd_s;
        default:         rdata_d              = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= {NUM_SRC{1'b0}};
      mask_q   <= {NUM_SRC{1'b0}};
      rdata_q  <= 32'd0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;

`ifdef ETH_INTR_COALESCE_EN
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;

  // HOLDOFF register write
  always_comb begin
    if (reg_wr && (reg_addr == ADDR_HOLDOFF)) begin
      holdoff_d = reg_wdata[HOLD_W-1:0];
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  // HOLDOFF register
  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff_q <= {HOLD_W{1'b0}};
    end else begin
      holdoff_q <= holdoff_d;
    end
  end

  assign holdoff_rd_s = holdoff_q;

  eth_intr_holdoff #(
    .HOLD_W(HOLD_W)
  ) u_holdoff (
    .clk           (clk),
    .rst           (rst),
    .pending_next_i(pending_next_s),
    .holdoff_i     (holdoff_q),
    .intr_o        (intr)
  );
`else
  logic intr_q;

  assign holdoff_rd_s = {HOLD_W{1'b0}};

  // intr follows pending with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= pending_next_s;
    end
  end

  assign intr = intr_q;
`endif

endmodule
